dlatch_checker: RTL

Synthesizable on-line checker for the level-sensitive D latch. It samples the latch's `d`, `en`, latch reset and `y` pins and checks them against an internal reference model. It counts enable pulses and behavioural mismatches and raises a sticky error. It sits beside the latch in simulation and FPGA bring-up and consumes the same signals the latch stimulus drives.

---
 rtl/dlatch_pkg.sv | 14 +
 rtl/sync_chain.sv | 23 ++
 rtl/dlatch_checker.sv | 76 +++++++
 3 files changed

// File: rtl/dlatch_pkg.sv
// dlatch_pkg: shared state encoding and saturating increment for the D-latch checker
package dlatch_pkg;
    localparam logic [1:0] ST_RESET    = 2'b00;
    localparam logic [1:0] ST_TRANSP   = 2'b01;
    localparam logic [1:0] ST_HOLD     = 2'b10;
    localparam logic [1:0] ST_REPORTED = 2'b11;

    // w is the counter width; the value sticks once it reaches all-ones at that width
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: DEPTH-stage flop synchronizer for a W-bit bus, cleared by active-low sync reset
module sync_chain #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/dlatch_checker.sv
// dlatch_checker: on-line checker comparing an observed D latch against a reference model
module dlatch_checker
    import dlatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_obs,
    input  logic             en_obs,
    input  logic             rst_obs,
    input  logic             y_obs,
    input  logic             clear,
    output logic             mismatch,
    output logic             error,
    output logic [CNT_W-1:0] en_pulses,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);
    logic [3:0] obs_s;
    logic       d_s, en_s, rst_s, y_s;
    logic [2:0] prev;
    logic [3:0] cnt, cnt_nxt;
    logic       exp_q, changed, armed, mis, en_rise;
    logic [1:0] base_st;

    sync_chain #(.DEPTH(SYNC_STAGES), .W(4)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    ({y_obs, rst_obs, en_obs, d_obs}),
        .q    (obs_s)
    );

    assign {y_s, rst_s, en_s, d_s} = obs_s;

    // The window is counted from the cycle a change becomes visible, so arming
    // looks at the counter's next value rather than its registered one.
    always_comb begin
        changed = obs_s[2:0] != prev;
        cnt_nxt = changed ? 4'(SETTLE) : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
        armed   = cnt_nxt == 4'd0;
        mis     = armed && (y_s != exp_q) && (state != ST_REPORTED);
        en_rise = en_s && !prev[1];
        base_st = !rst_s ? ST_RESET : (en_s ? ST_TRANSP : ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev      <= '0;
            cnt       <= 4'(SETTLE);
            exp_q     <= 1'b0;
            state     <= ST_RESET;
            mismatch  <= 1'b0;
            error     <= 1'b0;
            en_pulses <= '0;
            err_count <= '0;
        end else begin
            prev     <= obs_s[2:0];
            cnt      <= cnt_nxt;
            exp_q    <= !rst_s ? 1'b0 : (en_s ? d_s : exp_q);
            state    <= (mis || (state == ST_REPORTED && !changed)) ? ST_REPORTED : base_st;
            mismatch <= mis;
            if (clear) begin
                error     <= 1'b0;
                en_pulses <= '0;
                err_count <= '0;
            end else begin
                error <= error | mis;
                if (en_rise) en_pulses <= CNT_W'(sat_inc(32'(en_pulses), CNT_W));
                if (mis) err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
            end
        end
    end
endmodule
